// File: rtl/whiten_pkg.sv
// Shared types and LFSR helpers for the frame-level data whitener.
package whiten_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned TAP_HI = LFSR_W - 1;
    localparam int unsigned TAP_A  = 4;
    localparam int unsigned TAP_B  = 1;
    localparam int unsigned TAP_C  = 0;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = '1;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPayload,
        StDrop
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic fb;
        fb = cur[TAP_HI] ^ cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C];
        return {cur[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/whiten_lfsr.sv
// Whitening LFSR state with seed load and step; bit0_o reflects a same-cycle load.
module whiten_lfsr
    import whiten_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              bit0_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] seed_eff;
    logic [LFSR_W-1:0] cur;

    // An all-zero seed would lock the LFSR, so it is replaced by all ones.
    always_comb begin
        seed_eff = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        cur      = load_i ? seed_eff : lfsr_q;
        lfsr_d   = step_i ? lfsr_next(cur) : cur;
    end

    assign bit0_o = cur[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/whiten_frame_ctrl.sv
// Frame sequencer: header pass-through, LFSR-whitened payload, length/framing checks.
// Optional WHITEN_BYPASS_EN adds bypass_i to pass payload unwhitened per frame.
module whiten_frame_ctrl #(
    parameter int unsigned W           = 32,
    parameter int unsigned LFSR_W      = 16,
    parameter int unsigned HDR_CNT_W   = 4,
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    input  logic                 s_sop,
    input  logic                 s_eop,
    input  logic [LFSR_W-1:0]    seed_i,
    input  logic [HDR_CNT_W-1:0] hdr_words_i,
`ifdef WHITEN_BYPASS_EN
    input  logic                 bypass_i,
`endif
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [W-1:0]         m_data,
    output logic                 m_sop,
    output logic                 m_eop,
    output logic                 err_o,
    output logic [15:0]          frame_cnt_o
);
    import whiten_pkg::*;

    localparam int unsigned   PayW   = $clog2(MAX_PAYLOAD + 1);
    localparam logic [PayW-1:0] MaxPay = PayW'(MAX_PAYLOAD);

    state_e                 state_q, state_d;
    logic [HDR_CNT_W-1:0]   hdr_left_q, hdr_left_d;
    logic [PayW-1:0]        pay_cnt_q, pay_cnt_d;
    logic                   m_valid_q, m_valid_d;
    logic [W-1:0]           m_data_q, m_data_d;
    logic                   m_sop_q, m_sop_d;
    logic                   m_eop_q, m_eop_d;
    logic                   err_q, err_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;

    logic                   accept;
    logic                   lfsr_load, lfsr_step, lfsr_bit;
    logic                   bypass_now;
    logic                   is_hdr, is_pay;
    logic [HDR_CNT_W-1:0]   hdr_rem;
    logic [PayW-1:0]        pay_base, pay_nxt;

`ifdef WHITEN_BYPASS_EN
    logic bypass_q, bypass_d;
    assign bypass_now = s_sop ? bypass_i : bypass_q;
`else
    assign bypass_now = 1'b0;
`endif

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    whiten_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(lfsr_load),
        .step_i(lfsr_step),
        .seed_i(seed_i),
        .bit0_o(lfsr_bit)
    );

    always_comb begin
        state_d     = state_q;
        hdr_left_d  = hdr_left_q;
        pay_cnt_d   = pay_cnt_q;
        m_valid_d   = m_valid_q && !m_ready;
        m_data_d    = m_data_q;
        m_sop_d     = m_sop_q;
        m_eop_d     = m_eop_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        is_hdr      = 1'b0;
        is_pay      = 1'b0;
        hdr_rem     = hdr_left_q;
        pay_base    = pay_cnt_q;
        pay_nxt     = pay_cnt_q;
`ifdef WHITEN_BYPASS_EN
        bypass_d    = bypass_q;
`endif

        if (accept) begin
            // Any sop starts a fresh frame; outside IDLE it also abandons the current one.
            if (s_sop) begin
                lfsr_load = 1'b1;
                err_d     = (state_q != StIdle);
`ifdef WHITEN_BYPASS_EN
                bypass_d  = bypass_i;
`endif
                if (hdr_words_i != '0) begin
                    is_hdr  = 1'b1;
                    hdr_rem = hdr_words_i;
                end else begin
                    is_pay   = 1'b1;
                    pay_base = '0;
                end
            end else begin
                unique case (state_q)
                    StIdle:    err_d = 1'b1;
                    StHdr:     is_hdr = 1'b1;
                    StPayload: is_pay = 1'b1;
                    StDrop:    if (s_eop) state_d = StIdle;
                    default:   state_d = StIdle;
                endcase
            end

            if (is_hdr) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                m_sop_d   = s_sop;
                m_eop_d   = s_eop;
                if (s_eop) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end else if (hdr_rem == HDR_CNT_W'(1)) begin
                    pay_cnt_d = '0;
                    state_d   = StPayload;
                end else begin
                    hdr_left_d = hdr_rem - 1'b1;
                    state_d    = StHdr;
                end
            end

            if (is_pay) begin
                lfsr_step = 1'b1;
                pay_nxt   = pay_base + 1'b1;
                pay_cnt_d = pay_nxt;
                m_valid_d = 1'b1;
                m_data_d  = bypass_now ? s_data : (s_data ^ {W{lfsr_bit}});
                m_sop_d   = s_sop;
                m_eop_d   = s_eop;
                if (s_eop) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end else if (pay_nxt == MaxPay) begin
                    // Over-long frame: close it here and discard the remainder.
                    m_eop_d     = 1'b1;
                    err_d       = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StDrop;
                end else begin
                    state_d = StPayload;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hdr_left_q  <= '0;
            pay_cnt_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
`ifdef WHITEN_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_left_q  <= hdr_left_d;
            pay_cnt_q   <= pay_cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sop_q     <= m_sop_d;
            m_eop_q     <= m_eop_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef WHITEN_BYPASS_EN
            bypass_q    <= bypass_d;
`endif
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_sop       = m_sop_q;
    assign m_eop       = m_eop_q;
    assign err_o       = err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_whiten_frame_ctrl.sv
// Directed bench for whiten_frame_ctrl with an output scoreboard (MAX_PAYLOAD = 4).
module tb_whiten_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic [15:0] seed_i = '0;
    logic [3:0]  hdr_words_i = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic        err_o;
    logic [15:0] frame_cnt_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    logic [33:0] exp_q[$];
    logic [15:0] ml;
    logic [15:0] fc = '0;
    logic [31:0] exp_w;

    whiten_frame_ctrl #(
        .W          (32),
        .LFSR_W     (16),
        .HDR_CNT_W  (4),
        .MAX_PAYLOAD(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sop      (s_sop),
        .s_eop      (s_eop),
        .seed_i     (seed_i),
        .hdr_words_i(hdr_words_i),
`ifdef WHITEN_BYPASS_EN
        .bypass_i   (1'b0),
`endif
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .err_o      (err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reseed(input logic [15:0] s);
        ml = (s == 16'h0) ? 16'hFFFF : s;
    endtask

    task automatic wh(input logic [31:0] d, output logic [31:0] r);
        r  = d ^ {32{ml[0]}};
        ml = {ml[14:0], ml[15] ^ ml[4] ^ ml[1] ^ ml[0]};
    endtask

    task automatic expect_out(input logic sop, input logic eop, input logic [31:0] d);
        exp_q.push_back({sop, eop, d});
    endtask

    // Present one word, wait for acceptance, then check err_o and frame count.
    task automatic drive(input logic [31:0] d, input logic sop, input logic eop,
                         input logic exp_err);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", {63'h0, ok}, 64'h1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        check("err_o", {63'h0, err_o}, {63'h0, exp_err});
        check("frame_cnt", {48'h0, frame_cnt_o}, {48'h0, fc});
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            check("out_pending", {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
                check("out_word", {30'h0, m_sop, m_eop, m_data}, {30'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", {63'h0, m_valid}, 64'h0);
        check("rst_m_data", {32'h0, m_data}, 64'h0);
        check("rst_sop_eop", {62'h0, m_sop, m_eop}, 64'h0);
        check("rst_err", {63'h0, err_o}, 64'h0);
        check("rst_fcnt", {48'h0, frame_cnt_o}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two header words then two whitened payload words.
        seed_i = 16'hACE1;
        hdr_words_i = 4'd2;
        expect_out(1'b1, 1'b0, 32'h11111111); drive(32'h11111111, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 1'b0, 32'h22222222); drive(32'h22222222, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 1'b0, 32'hCCCCCCCC); drive(32'h33333333, 1'b0, 1'b0, 1'b0);
        fc = 16'd1;
        expect_out(1'b0, 1'b1, 32'h44444444); drive(32'h44444444, 1'b0, 1'b1, 1'b0);

        // Zero seed becomes all ones; one-word frame.
        seed_i = 16'h0000;
        hdr_words_i = 4'd0;
        fc = 16'd2;
        expect_out(1'b1, 1'b1, 32'hFFFFFFFF); drive(32'h00000000, 1'b1, 1'b1, 1'b0);

        // Downstream stall in the middle of a frame.
        seed_i = 16'h1234;
        hdr_words_i = 4'd1;
        reseed(16'h1234);
        expect_out(1'b1, 1'b0, 32'hA0A0A0A0); drive(32'hA0A0A0A0, 1'b1, 1'b0, 1'b0);
        wh(32'h01020304, exp_w);
        expect_out(1'b0, 1'b0, exp_w); drive(32'h01020304, 1'b0, 1'b0, 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h05060708;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_s_ready", {63'h0, s_ready}, 64'h0);
            check("stall_m_data", {31'h0, m_valid, m_data}, {31'h0, 1'b1, exp_w});
        end
        m_ready = 1'b1;
        wh(32'h05060708, exp_w);
        expect_out(1'b0, 1'b0, exp_w); drive(32'h05060708, 1'b0, 1'b0, 1'b0);
        wh(32'h090A0B0C, exp_w);
        fc = 16'd3;
        expect_out(1'b0, 1'b1, exp_w); drive(32'h090A0B0C, 1'b0, 1'b1, 1'b0);

        // Seven-word frame against a four-word payload limit.
        seed_i = 16'hBEEF;
        hdr_words_i = 4'd0;
        reseed(16'hBEEF);
        for (int i = 0; i < 7; i++) begin
            logic [31:0] d;
            d = 32'h1000_0000 + 32'(i);
            if (i < 3) begin
                wh(d, exp_w);
                expect_out(i == 0, 1'b0, exp_w);
                drive(d, i == 0, 1'b0, 1'b0);
            end else if (i == 3) begin
                wh(d, exp_w);
                fc = 16'd4;
                expect_out(1'b0, 1'b1, exp_w);
                drive(d, 1'b0, 1'b0, 1'b1);
            end else begin
                drive(d, 1'b0, i == 6, 1'b0);
            end
        end
        seed_i = 16'h0001;
        reseed(16'h0001);
        wh(32'h5555AAAA, exp_w);
        fc = 16'd5;
        expect_out(1'b1, 1'b1, exp_w); drive(32'h5555AAAA, 1'b1, 1'b1, 1'b0);

        // Stray word in IDLE, then a sop interrupting the payload.
        drive(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        seed_i = 16'h00F0;
        hdr_words_i = 4'd1;
        reseed(16'h00F0);
        expect_out(1'b1, 1'b0, 32'h12345678); drive(32'h12345678, 1'b1, 1'b0, 1'b0);
        wh(32'h0F0F0F0F, exp_w);
        expect_out(1'b0, 1'b0, exp_w); drive(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
        seed_i = 16'h5A5B;
        hdr_words_i = 4'd0;
        reseed(16'h5A5B);
        wh(32'h87654321, exp_w);
        expect_out(1'b1, 1'b0, exp_w); drive(32'h87654321, 1'b1, 1'b0, 1'b1);
        wh(32'hCAFEF00D, exp_w);
        fc = 16'd6;
        expect_out(1'b0, 1'b1, exp_w); drive(32'hCAFEF00D, 1'b0, 1'b1, 1'b0);

        // Reset while a payload word sits stalled in the output register.
        seed_i = 16'h7777;
        reseed(16'h7777);
        wh(32'h01010101, exp_w);
        expect_out(1'b1, 1'b0, exp_w); drive(32'h01010101, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        drive(32'h02020202, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", {63'h0, m_valid}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'h0, m_valid}, 64'h0);
        check("mid_rst_fcnt", {48'h0, frame_cnt_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        fc      = 16'd0;
        @(posedge clk);
        #1;
        seed_i = 16'h0003;
        reseed(16'h0003);
        wh(32'hAAAA5555, exp_w);
        expect_out(1'b1, 1'b0, exp_w); drive(32'hAAAA5555, 1'b1, 1'b0, 1'b0);
        wh(32'h00FF00FF, exp_w);
        fc = 16'd1;
        expect_out(1'b0, 1'b1, exp_w); drive(32'h00FF00FF, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", {32'h0, exp_q.size()}, 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
